// File: rtl/otter_hazard_pkg.sv
// Shared types for the OTTER hazard unit: forwarding selects, FSM states and shadow entries.
// Optional feature macro: OTTER_FWD_WB_BYPASS_EN (adds the retired write-back select).
package otter_hazard_pkg;

    localparam int unsigned NumRegs = 32;
    localparam int unsigned RegW    = $clog2(NumRegs);

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2,
        FWD_RET   = 2'd3
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic            valid;
        logic [RegW-1:0] rd;
        logic            we;
        logic            ld;
    } shadow_t;

    // x0 is hardwired to zero, so it never produces a dependency.
    function automatic logic src_match(shadow_t e, logic [RegW-1:0] s, logic used);
        return e.valid & e.we & (e.rd == s) & (s != '0) & used;
    endfunction

endpackage

// File: rtl/otter_hazard_if.sv
// Decode/EX/MEM control signals exchanged between the OTTER pipeline and its hazard unit.
// Optional feature macro: OTTER_FWD_WB_BYPASS_EN (widens nothing; select 3 becomes reachable).
interface otter_hazard_if #(
    parameter int unsigned XLEN_REGS = 32
);
    localparam int unsigned RW = $clog2(XLEN_REGS);

    logic          dec_valid;
    logic [RW-1:0] dec_rs1;
    logic [RW-1:0] dec_rs2;
    logic          dec_rs1_used;
    logic          dec_rs2_used;
    logic [RW-1:0] dec_rd;
    logic          dec_reg_write;
    logic          dec_is_load;
    logic          ex_branch_taken;
    logic          mem_stall;
    logic [1:0]    fwd_a_sel;
    logic [1:0]    fwd_b_sel;
    logic          stall_if;
    logic          bubble_ex;
    logic          flush_de;
    logic [1:0]    state_o;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
        output dec_rd, dec_reg_write, dec_is_load, ex_branch_taken, mem_stall,
        input  fwd_a_sel, fwd_b_sel, stall_if, bubble_ex, flush_de, state_o
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
        input  dec_rd, dec_reg_write, dec_is_load, ex_branch_taken, mem_stall,
        output fwd_a_sel, fwd_b_sel, stall_if, bubble_ex, flush_de, state_o
    );

endinterface

// File: rtl/otter_fwd_select.sv
// Per-operand forwarding priority encoder; the youngest matching producer wins.
// Optional feature macro: OTTER_FWD_WB_BYPASS_EN (selects the retired latch on a WB-only match).
module otter_fwd_select
    import otter_hazard_pkg::*;
(
    input  logic [RegW-1:0] src_i,
    input  logic            used_i,
    input  shadow_t         sh_ex_i,
    input  shadow_t         sh_mem_i,
`ifdef OTTER_FWD_WB_BYPASS_EN
    input  shadow_t         sh_wb_i,
`endif
    output fwd_sel_t        sel_o
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = src_match(sh_ex_i, src_i, used_i);
    assign mem_hit = src_match(sh_mem_i, src_i, used_i);

    always_comb begin
        sel_o = FWD_RF;
        // A matching load in EX cannot forward yet; the load-use stall covers it.
        if (ex_hit && !sh_ex_i.ld) begin
            sel_o = FWD_EXMEM;
        end else if (mem_hit) begin
            sel_o = FWD_MEMWB;
        end
`ifdef OTTER_FWD_WB_BYPASS_EN
        else if (src_match(sh_wb_i, src_i, used_i)) begin
            sel_o = FWD_RET;
        end
`endif
    end

    logic unused_ld;
`ifdef OTTER_FWD_WB_BYPASS_EN
    assign unused_ld = sh_mem_i.ld ^ sh_wb_i.ld;
`else
    assign unused_ld = sh_mem_i.ld;
`endif

endmodule

// File: rtl/otter_hazard_unit.sv
// OTTER 5-stage hazard unit: registered EX forwarding selects, load-use stall and branch flush.
// Optional feature macro: OTTER_FWD_WB_BYPASS_EN (adds sh_ret and forwarding select 3).
module otter_hazard_unit
    import otter_hazard_pkg::*;
#(
    parameter int unsigned XLEN_REGS = NumRegs
) (
    input  logic            CLK,
    input  logic            RST_N,
    otter_hazard_if.slave   hz
);

    localparam int unsigned RW = $clog2(XLEN_REGS);

    logic [RW-1:0]   rs1_raw;
    logic [RW-1:0]   rs2_raw;
    logic [RW-1:0]   rd_raw;
    logic [RegW-1:0] rs1;
    logic [RegW-1:0] rs2;
    shadow_t         de_entry;

    assign rs1_raw  = hz.dec_rs1;
    assign rs2_raw  = hz.dec_rs2;
    assign rd_raw   = hz.dec_rd;
    assign rs1      = RegW'(rs1_raw);
    assign rs2      = RegW'(rs2_raw);
    assign de_entry = '{valid: hz.dec_valid, rd: RegW'(rd_raw), we: hz.dec_reg_write,
                        ld: hz.dec_is_load};

    shadow_t   sh_ex_q, sh_ex_d;
    shadow_t   sh_mem_q, sh_mem_d;
    shadow_t   sh_wb_q, sh_wb_d;
    fwd_sel_t  fwd_a_q, fwd_a_d;
    fwd_sel_t  fwd_b_q, fwd_b_d;
    hz_state_t state_q, state_d;
`ifdef OTTER_FWD_WB_BYPASS_EN
    shadow_t   sh_ret_q, sh_ret_d;
`endif

    fwd_sel_t sel_a;
    fwd_sel_t sel_b;

    otter_fwd_select u_fwd_a (
        .src_i    (rs1),
        .used_i   (hz.dec_rs1_used),
        .sh_ex_i  (sh_ex_q),
        .sh_mem_i (sh_mem_q),
`ifdef OTTER_FWD_WB_BYPASS_EN
        .sh_wb_i  (sh_wb_q),
`endif
        .sel_o    (sel_a)
    );

    otter_fwd_select u_fwd_b (
        .src_i    (rs2),
        .used_i   (hz.dec_rs2_used),
        .sh_ex_i  (sh_ex_q),
        .sh_mem_i (sh_mem_q),
`ifdef OTTER_FWD_WB_BYPASS_EN
        .sh_wb_i  (sh_wb_q),
`endif
        .sel_o    (sel_b)
    );

    logic load_use;
    assign load_use = hz.dec_valid & sh_ex_q.ld &
                      (src_match(sh_ex_q, rs1, hz.dec_rs1_used) |
                       src_match(sh_ex_q, rs2, hz.dec_rs2_used));

    logic stall_if;
    logic bubble_ex;
    logic flush_de;

    always_comb begin
        sh_ex_d   = sh_ex_q;
        sh_mem_d  = sh_mem_q;
        sh_wb_d   = sh_wb_q;
        fwd_a_d   = fwd_a_q;
        fwd_b_d   = fwd_b_q;
        state_d   = state_q;
        stall_if  = 1'b0;
        bubble_ex = 1'b0;
        flush_de  = 1'b0;
`ifdef OTTER_FWD_WB_BYPASS_EN
        sh_ret_d  = sh_ret_q;
`endif

        if (hz.mem_stall) begin
            stall_if = 1'b1;
        end else begin
            if (hz.ex_branch_taken) begin
                flush_de  = 1'b1;
                bubble_ex = 1'b1;
            end else if (load_use) begin
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
            end

            unique case (state_q)
                RUN: begin
                    if (hz.ex_branch_taken) begin
                        state_d = FLUSH;
                    end else if (load_use) begin
                        state_d = LDSTALL;
                    end else begin
                        state_d = RUN;
                    end
                end
                LDSTALL, FLUSH: state_d = RUN;
                default:        state_d = RUN;
            endcase

            sh_wb_d  = sh_mem_q;
            sh_mem_d = sh_ex_q;
`ifdef OTTER_FWD_WB_BYPASS_EN
            sh_ret_d = sh_wb_q;
`endif
            if (bubble_ex || !hz.dec_valid) begin
                sh_ex_d = '0;
                fwd_a_d = FWD_RF;
                fwd_b_d = FWD_RF;
            end else begin
                sh_ex_d = de_entry;
                fwd_a_d = sel_a;
                fwd_b_d = sel_b;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sh_ex_q  <= '0;
            sh_mem_q <= '0;
            sh_wb_q  <= '0;
            fwd_a_q  <= FWD_RF;
            fwd_b_q  <= FWD_RF;
            state_q  <= RUN;
`ifdef OTTER_FWD_WB_BYPASS_EN
            sh_ret_q <= '0;
`endif
        end else begin
            sh_ex_q  <= sh_ex_d;
            sh_mem_q <= sh_mem_d;
            sh_wb_q  <= sh_wb_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
            state_q  <= state_d;
`ifdef OTTER_FWD_WB_BYPASS_EN
            sh_ret_q <= sh_ret_d;
`endif
        end
    end

    assign hz.fwd_a_sel = fwd_a_q;
    assign hz.fwd_b_sel = fwd_b_q;
    assign hz.stall_if  = stall_if;
    assign hz.bubble_ex = bubble_ex;
    assign hz.flush_de  = flush_de;
    assign hz.state_o   = state_q;

    // sh_wb only feeds the bypass select; sh_ret is kept for the retired write-back latch.
    logic unused_shadow;
`ifdef OTTER_FWD_WB_BYPASS_EN
    assign unused_shadow = ^{sh_ret_q};
`else
    assign unused_shadow = ^{sh_wb_q};
`endif

endmodule

// File: doc/otter_hazard_unit.md
Name: otter_hazard_unit

Overview:
- Pipeline control block for the 5-stage OTTER (IF, DE, EX, MEM, WB).
- Produces the 2-bit select codes that drive the EX-stage 4-to-1 operand forwarding muxes, plus the load-use stall and branch flush controls.
- Keeps its own shadow pipeline of destination-register metadata, so the select codes are registered and line up with the instruction entering EX.

Parameters:
- XLEN_REGS, 32: number of architectural registers; sets the rs/rd width as log2, which is 5 by default.

Ports:
- CLK  input  1  system clock, rising edge
- RST_N  input  1  asynchronous, active-low reset
- dec_valid  input  1  the DE stage holds a real instruction
- dec_rs1  input  5  DE source register 1
- dec_rs2  input  5  DE source register 2
- dec_rs1_used  input  1  the instruction reads rs1
- dec_rs2_used  input  1  the instruction reads rs2
- dec_rd  input  5  DE destination register
- dec_reg_write  input  1  the DE instruction writes rd
- dec_is_load  input  1  the DE instruction is a load
- ex_branch_taken  input  1  the EX stage resolved a taken branch or jump
- mem_stall  input  1  data memory is not ready; freeze the whole pipeline
- fwd_a_sel  output  2  operand A mux select, registered
- fwd_b_sel  output  2  operand B mux select, registered
- stall_if  output  1  hold the PC and the IF/DE register
- bubble_ex  output  1  insert a NOP into the DE/EX register
- flush_de  output  1  invalidate the IF/DE register
- state_o  output  2  current FSM state, for debug

Behaviour:
- Select encoding, shared by both operands:
  - 0 = register-file value
  - 1 = EX/MEM ALU result
  - 2 = MEM/WB write-back data
  - 3 = retired write-back latch; produced only with the optional feature
- Shadow pipeline: three entries, sh_ex, sh_mem and sh_wb. Each holds {valid, rd, we, ld}.
- While mem_stall=1: all shadow entries, fwd_*_sel and the FSM hold their values. stall_if=1; bubble_ex=0; flush_de=0.
- Otherwise the shadow pipeline advances each cycle: sh_wb<=sh_mem and sh_mem<=sh_ex.
  - sh_ex takes the DE entry, or a bubble (valid=0) on a load-use hazard or a flush.
- Hazard match: source s matches entry e when e.valid & e.we & (e.rd==s) & (s!=0) & s_used. x0 is never forwarded and never stalls.
- Load-use hazard: dec_valid & a source matches sh_ex & sh_ex.ld. Effect: stall_if=1 and bubble_ex=1 for exactly one cycle.
- Select computation for each operand, performed when the DE entry advances:
  - sh_ex matches and is not a load -> 1
  - else sh_mem matches -> 2
  - else -> 0
  - The youngest producer always wins.
- Registered output: fwd_*_sel is loaded with the computed value. It is loaded with 0 on a bubble or a flush.
- FSM states: RUN=0, LDSTALL=1, FLUSH=2.
  - RUN -> LDSTALL on a load-use hazard.
  - RUN -> FLUSH on ex_branch_taken.
  - LDSTALL -> RUN after one cycle. The re-evaluated instruction then sees the load in sh_mem and gets select 2.
  - FLUSH -> RUN after one cycle.
  - FLUSH outputs: flush_de=1 and bubble_ex=1, asserted in the same cycle as ex_branch_taken.
- Priority: mem_stall > ex_branch_taken > load-use. A taken branch during a load-use hazard flushes and does not stall.
- Outputs are combinational from the state and inputs, except fwd_*_sel.
- Reset with RST_N=0:
  - all shadow valid bits = 0
  - fwd_a_sel = fwd_b_sel = 0
  - state = RUN
  - stall_if = bubble_ex = flush_de = 0
- Reset has immediate effect and may be asserted mid-stall; the first post-reset cycle is RUN.

Optional Feature:
- Macro: OTTER_FWD_WB_BYPASS_EN.
- When defined:
  - Adds a fourth shadow entry, sh_ret, which is sh_wb delayed by one cycle.
  - When neither sh_ex nor sh_mem matches but sh_wb matches, select = 3. This supports a register file without write-first behaviour.
- When undefined:
  - The register file is write-first; select 3 is never produced and sh_ret is absent.
  - When only sh_wb matches, select = 0.

Decomposition:
- Package otter_hazard_pkg holds:
  - enum fwd_sel_t {FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_RET}
  - enum hz_state_t {RUN, LDSTALL, FLUSH}
  - struct shadow_t {valid, rd, we, ld}
- Sub-module otter_fwd_select: combinational per-operand priority encoder. It is instantiated twice, once for rs1 and once for rs2.

Test Plan:
- ADD x5 then ADD x6,x5,x1 back-to-back -> fwd_a_sel=1 when the second instruction is in EX; no stall.
- ADD x5, NOP, then SUB x7,x2,x5 -> fwd_b_sel=2.
- LW x5, then ADD x6,x5,x5 -> stall_if=1 and bubble_ex=1 for one cycle, state_o=1. Next cycle: fwd_a_sel=fwd_b_sel=2.
- ADDI x0,x0,1, then ADD x1,x0,x0 -> selects 0; no stall.
- LW x5 followed by a dependent instruction, with ex_branch_taken=1 in the same cycle -> flush_de=1, bubble_ex=1, stall_if=0, state_o=2.
- mem_stall=1 for 3 cycles mid-stream -> selects and state hold; forwarding resumes correctly. RST_N pulsed low during LDSTALL -> all outputs 0, state RUN.
